iq_buf_reader: RTL and testbench
================================

// Module: iq_buf_reader
// PURPOSE
//  Drain side of the IQ record ring buffer. Detects complete records (read ptr != write ptr).
//  Fetches each record word-by-word over the register-read port and emits it as a 32-bit stream
//  with tlast on the record's final word. Then advances iq_buf_read so the writer can reuse the slot.
//  Sits between the IQ buffer RAM (reg port) and the AXI-stream/DMA path to the host.
// PARAMETERS
//  ADC_CHANNEL  8   ADC channels per record
//  FREQ_NUM     5   demod frequencies per channel
//  BUF_NUM      80  records in the ring
//  REG_NUM (localparam) = ADC_CHANNEL*FREQ_NUM*2+3 (=83), 32-bit words per record
// PORTS
//  clk            in   1   system clock
//  rst            in   1   asynchronous active-high reset
//  enable         in   1   1 = start new records; 0 = finish current record, then idle
//  iq_buf_write   in   16  writer base pointer, word index, multiple of REG_NUM
//  iq_buf_rst     in   1   sync clear of ring pointers (shared with writer)
//  iq_buf_read    out  16  reader base pointer, word index, multiple of REG_NUM
//  reg_addr       out  16  RAM word address = iq_buf_read + word_idx
//  reg_rd         out  1   read request, held until reg_ready
//  reg_readdata   in   32  read data, valid in the cycle reg_ready=1
//  reg_ready      in   1   read completion strobe
//  m_tdata        out  32  stream data
//  m_tvalid       out  1   stream valid
//  m_tready       in   1   stream ready
//  m_tlast        out  1   last word of record (or of aborted record)
//  m_tuser        out  1   1 on final word of a record truncated by iq_buf_rst
//  rec_count      out  32  records fully streamed since rst/iq_buf_rst, wraps at 2^32
//  busy           out  1   FSM not in IDLE
// BEHAVIOUR
//  Async rst: every output = 0, FSM = IDLE, word_idx = 0.
//  Empty: iq_buf_read == iq_buf_write.
//  FSM states: IDLE, REQ, PUSH, ADV, FLUSH.
//  - IDLE: if enable and not empty, go to REQ next cycle; reg_rd=1 in that cycle, word_idx=0.
//  - REQ: reg_rd and reg_addr held stable until reg_ready=1.
//    On reg_ready: capture reg_readdata into m_tdata; reg_rd=0 next cycle; go to PUSH with m_tvalid=1.
//    Only one read is outstanding at a time.
//  - PUSH: m_tvalid stays 1 and m_tdata/m_tlast stay stable until m_tready=1.
//    m_tlast=1 iff word_idx == REG_NUM-1.
//    On accept: if not last, word_idx++ and go to REQ; if last, go to ADV.
//  - ADV (1 cycle):
//    iq_buf_read <= (iq_buf_read >= REG_NUM*(BUF_NUM-1)) ? 0 : iq_buf_read+REG_NUM.
//    rec_count++. Go to IDLE.
//  Latency: a record in IDLE appears as reg_rd 1 cycle after the write pointer moves.
//  Full throughput with zero-wait RAM and m_tready=1: 1 word per 2 cycles.
//  enable dropping mid-record: no effect until ADV; IDLE then holds while enable=0.
//  iq_buf_rst:
//  - In IDLE or ADV: iq_buf_read=0, rec_count=0, go to IDLE; ADV increments are suppressed.
//  - In REQ: set an abort flag. Keep reg_rd until reg_ready, then present the captured word
//    with m_tlast=1, m_tuser=1.
//  - In PUSH: the pending word keeps m_tdata stable and m_tlast/m_tuser are forced to 1.
//  - In either abort case, after the accept go to FLUSH (1 cycle): clear iq_buf_read,
//    rec_count and word_idx, then go to IDLE. tvalid never drops before acceptance.
//  Writer overrunning reader: not detected here (the writer flags overflow).
//  The reader never reads past iq_buf_write: the non-empty check happens only in IDLE,
//  and the writer publishes whole records.
// TESTING
//  1 Writer ptr 0->83, m_tready=1, 1-cycle reg_ready:
//    -> 83 beats with addr 0..82, tlast on beat 83; iq_buf_read=83; rec_count=1.
//  2 Read ptr at 83*79=6557, write ptr 0 after wrap:
//    -> addr 6557..6639 read; iq_buf_read wraps to 0; returns to IDLE because empty.
//  3 Random m_tready (50%) and reg_ready delay 0-5 cycles:
//    -> data matches RAM model in order; tvalid/tdata stable while stalled; no duplicate reads.
//  4 iq_buf_rst while REQ waits reg_ready (word 10):
//    -> reg_rd held until ready; beat with tlast=1, tuser=1; then iq_buf_read=0, rec_count=0.
//  5 enable=0 at word 40:
//    -> record completes, iq_buf_read advances; no new reg_rd while 2 records still pending.
//  6 Async rst asserted mid-PUSH:
//    -> all outputs 0 immediately; after release with write ptr 166, two records stream from addr 0.

Source files
------------

// File: rtl/iq_buf_reader.sv
// Drain side of the IQ record ring: fetches whole records over the
// register-read port and streams them out with tlast on the final word.
module iq_buf_reader #(
   parameter int ADC_CHANNEL = 8,
   parameter int FREQ_NUM    = 5,
   parameter int BUF_NUM     = 80
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic [15:0] iq_buf_write,
   input  logic        iq_buf_rst,
   output logic [15:0] iq_buf_read,
   output logic [15:0] reg_addr,
   output logic        reg_rd,
   input  logic [31:0] reg_readdata,
   input  logic        reg_ready,
   output logic [31:0] m_tdata,
   output logic        m_tvalid,
   input  logic        m_tready,
   output logic        m_tlast,
   output logic        m_tuser,
   output logic [31:0] rec_count,
   output logic        busy
);

   localparam int REG_NUM = ADC_CHANNEL*FREQ_NUM*2+3;
   localparam logic [15:0] REC_W     = 16'(REG_NUM);
   localparam logic [15:0] LAST_IDX  = 16'(REG_NUM-1);
   localparam logic [15:0] LAST_BASE = 16'(REG_NUM*(BUF_NUM-1));

   typedef enum logic [2:0] {
      S_IDLE, S_REQ, S_PUSH, S_ADV, S_FLUSH
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] idx_q, idx_d;
   logic [15:0] rd_ptr_q, rd_ptr_d;
   logic [31:0] cnt_q, cnt_d;
   logic [31:0] data_q, data_d;
   logic        abort_q, abort_d;
   logic        abort_now;
   logic        is_last;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         idx_q    <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         data_q   <= '0;
         abort_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         data_q   <= data_d;
         abort_q  <= abort_d;
      end
   end

   // A ring reset arriving mid-record truncates it at the word in flight.
   assign abort_now = abort_q | iq_buf_rst;
   assign is_last   = (idx_q == LAST_IDX);

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      data_d   = data_q;
      abort_d  = abort_q;
      unique case (state_q)
         S_IDLE: begin
            idx_d = '0;
            if (iq_buf_rst) begin
               rd_ptr_d = '0;
               cnt_d    = '0;
            end else if (enable && (rd_ptr_q != iq_buf_write)) begin
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            abort_d = abort_now;
            if (reg_ready) begin
               data_d  = reg_readdata;
               state_d = S_PUSH;
            end
         end
         S_PUSH: begin
            abort_d = abort_now;
            if (m_tready) begin
               if (abort_now) begin
                  state_d = S_FLUSH;
               end else if (is_last) begin
                  state_d = S_ADV;
               end else begin
                  idx_d   = idx_q + 16'd1;
                  state_d = S_REQ;
               end
            end
         end
         S_ADV: begin
            idx_d   = '0;
            state_d = S_IDLE;
            if (iq_buf_rst) begin
               rd_ptr_d = '0;
               cnt_d    = '0;
            end else begin
               rd_ptr_d = (rd_ptr_q >= LAST_BASE) ? 16'd0
                                                  : rd_ptr_q + REC_W;
               cnt_d    = cnt_q + 32'd1;
            end
         end
         S_FLUSH: begin
            rd_ptr_d = '0;
            cnt_d    = '0;
            idx_d    = '0;
            abort_d  = 1'b0;
            state_d  = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign iq_buf_read = rd_ptr_q;
   assign reg_addr    = rd_ptr_q + idx_q;
   assign reg_rd      = (state_q == S_REQ);
   assign m_tdata     = data_q;
   assign m_tvalid    = (state_q == S_PUSH);
   assign m_tlast     = m_tvalid & (is_last | abort_now);
   assign m_tuser     = m_tvalid & abort_now;
   assign rec_count   = cnt_q;
   assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_iq_buf_reader.sv
// Scoreboard bench for iq_buf_reader: a RAM responder serves reads,
// expected beats are queued as records are published, a monitor checks.
module tb_iq_buf_reader;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        enable = 1'b1;
   logic [15:0] iq_buf_write = '0;
   logic        iq_buf_rst = 1'b0;
   logic [15:0] iq_buf_read;
   logic [15:0] reg_addr;
   logic        reg_rd;
   logic [31:0] reg_readdata;
   logic        reg_ready;
   logic [31:0] m_tdata;
   logic        m_tvalid;
   logic        m_tready = 1'b1;
   logic        m_tlast;
   logic        m_tuser;
   logic [31:0] rec_count;
   logic        busy;

   typedef struct packed {
      logic [31:0] d;
      logic        l;
      logic        u;
   } beat_t;

   beat_t q[$];
   int total = 0;
   int bad = 0;
   int nreads = 0;
   int rd_seen;
   bit rand_mode = 0;
   bit rand_tr = 0;
   bit stall_en = 0;
   bit stall_rel = 0;
   logic [15:0] stall_addr = '0;

   iq_buf_reader dut (
      .clk(clk), .rst(rst), .enable(enable),
      .iq_buf_write(iq_buf_write), .iq_buf_rst(iq_buf_rst),
      .iq_buf_read(iq_buf_read), .reg_addr(reg_addr),
      .reg_rd(reg_rd), .reg_readdata(reg_readdata),
      .reg_ready(reg_ready), .m_tdata(m_tdata),
      .m_tvalid(m_tvalid), .m_tready(m_tready),
      .m_tlast(m_tlast), .m_tuser(m_tuser),
      .rec_count(rec_count), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] ram(input logic [15:0] a);
      return {a, ~a};
   endfunction

   task automatic chk(input string n, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", n, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_rec(input logic [15:0] base);
      for (int i = 0; i < 83; i++)
         q.push_back('{ram(base + 16'(i)), (i == 82), 1'b0});
   endtask

   task automatic wait_rd(input logic [15:0] v, input int n);
      for (int i = 0; i < n && iq_buf_read != v; i++) tick();
   endtask

   // RAM responder: one read at a time, optional random latency or stall.
   initial begin
      logic [15:0] a;
      int d;
      reg_ready = 1'b0;
      reg_readdata = '0;
      forever begin
         tick();
         if (reg_rd && !rst) begin
            a = reg_addr;
            nreads++;
            d = rand_mode ? int'($urandom_range(0, 5)) : 0;
            for (int i = 0; i < d; i++) begin
               tick();
               chk("addr_hold", {15'd0, reg_rd, reg_addr}, {16'h1, a});
            end
            for (int i = 0; i < 1000 && stall_en && a == stall_addr
                 && !stall_rel; i++) tick();
            reg_ready = 1'b1;
            reg_readdata = ram(a);
            tick();
            reg_ready = 1'b0;
         end
      end
   end

   initial begin
      forever begin
         tick();
         if (rand_tr) m_tready = 1'($urandom_range(0, 1));
      end
   end

   // Monitor: pops on every handshake, checks hold while stalled.
   initial begin
      bit pv = 0;
      bit pacc = 0;
      logic [31:0] pd = '0;
      beat_t e;
      forever begin
         @(negedge clk);
         if (rst) begin
            pv = 0;
         end else begin
            if (pv && !pacc)
               chk("stall_hold", {m_tvalid, m_tdata[30:0]},
                   {1'b1, pd[30:0]});
            if (m_tvalid && m_tready) begin
               if (q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL extra_beat: got %0h want none", m_tdata);
               end else begin
                  e = q.pop_front();
                  chk("beat", {m_tdata, 2'b0, m_tlast, m_tuser},
                      {e.d, 2'b0, e.l, e.u});
               end
            end
            pv = m_tvalid;
            pacc = m_tready;
            pd = m_tdata;
         end
      end
   end

   initial begin
      repeat (3) tick();
      chk("rst_read", iq_buf_read, 0);
      chk("rst_cnt", rec_count, 0);
      chk("rst_flags", {busy, reg_rd, m_tvalid}, 0);
      rst = 1'b0;
      tick();

      // 1: single record, latency and pointer advance
      iq_buf_write = 16'd83;
      push_rec(0);
      tick();
      chk("t1_latency", {15'd0, reg_rd, reg_addr}, {16'h1, 16'd0});
      wait_rd(83, 1000);
      chk("t1_read", iq_buf_read, 83);
      chk("t1_cnt", rec_count, 1);

      // 2: drain to the last slot, then wrap
      iq_buf_write = 16'd6557;
      for (int k = 1; k < 79; k++) push_rec(16'(83 * k));
      wait_rd(6557, 20000);
      chk("t2_read", iq_buf_read, 6557);
      chk("t2_cnt", rec_count, 79);
      iq_buf_write = 16'd0;
      push_rec(6557);
      wait_rd(0, 1000);
      chk("t2_wrap", iq_buf_read, 0);
      chk("t2_cnt80", rec_count, 80);
      repeat (3) tick();
      chk("t2_idle", {busy, reg_rd}, 0);
      chk("t2_q", q.size(), 0);

      // 3: random RAM latency and stream backpressure
      nreads = 0;
      rand_mode = 1;
      rand_tr = 1;
      iq_buf_write = 16'd166;
      push_rec(0);
      push_rec(83);
      wait_rd(166, 8000);
      rand_mode = 0;
      rand_tr = 0;
      m_tready = 1'b1;
      chk("t3_read", iq_buf_read, 166);
      chk("t3_cnt", rec_count, 82);
      chk("t3_reads", nreads, 166);
      chk("t3_q", q.size(), 0);

      // 4: ring reset while word 10 waits on the RAM
      stall_en = 1;
      stall_addr = 16'd176;
      iq_buf_write = 16'd249;
      for (int i = 0; i < 10; i++)
         q.push_back('{ram(16'(166 + i)), 1'b0, 1'b0});
      q.push_back('{ram(16'd176), 1'b1, 1'b1});
      for (int i = 0; i < 500 && !(reg_rd && reg_addr == 16'd176); i++)
         tick();
      tick();
      iq_buf_rst = 1'b1;
      iq_buf_write = 16'd0;
      tick();
      iq_buf_rst = 1'b0;
      repeat (3) tick();
      chk("t4_rd_held", {15'd0, reg_rd, reg_addr}, {16'h1, 16'd176});
      stall_rel = 1;
      repeat (10) tick();
      stall_en = 0;
      stall_rel = 0;
      chk("t4_read", iq_buf_read, 0);
      chk("t4_cnt", rec_count, 0);
      chk("t4_idle", {busy, reg_rd}, 0);
      chk("t4_q", q.size(), 0);

      // 5: enable drops mid-record
      iq_buf_write = 16'd249;
      push_rec(0);
      for (int i = 0; i < 500 && !(reg_rd && reg_addr == 16'd40); i++)
         tick();
      enable = 1'b0;
      wait_rd(83, 1000);
      chk("t5_read", iq_buf_read, 83);
      chk("t5_cnt", rec_count, 1);
      rd_seen = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (reg_rd || busy) rd_seen++;
      end
      chk("t5_quiet", rd_seen, 0);

      // 6: async reset while a beat is stalled
      m_tready = 1'b0;
      enable = 1'b1;
      for (int i = 0; i < 50 && !m_tvalid; i++) tick();
      chk("t6_push", {31'd0, m_tvalid}, 1);
      rst = 1'b1;
      #1;
      chk("t6_rst_a", {iq_buf_read, reg_addr}, 0);
      chk("t6_rst_b", m_tdata | rec_count, 0);
      chk("t6_rst_c", {busy, reg_rd, m_tvalid, m_tlast, m_tuser}, 0);
      iq_buf_write = 16'd166;
      m_tready = 1'b1;
      push_rec(0);
      push_rec(83);
      tick();
      rst = 1'b0;
      wait_rd(166, 2000);
      chk("t6_read", iq_buf_read, 166);
      chk("t6_cnt", rec_count, 2);
      chk("t6_q", q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got running want finished");
      $fatal(1);
   end

endmodule
